// File: rtl/rectangle_key_sched_pkg.sv
// rectangle_pkg: shared constants, types and helpers for the RECTANGLE key schedule
package rectangle_pkg;

    typedef logic [63:0] rk_t;

    typedef enum logic {IDLE, EMIT} ks_state_t;

    localparam logic [4:0] RC_INIT = 5'h01;

    localparam logic [3:0] SBOX [16] = '{
        4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
        4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
    };

    function automatic int row_w(input int key_w);
        return (key_w == 128) ? 32 : 16;
    endfunction

    function automatic int col_n(input int key_w);
        return (key_w == 128) ? 8 : 4;
    endfunction

    function automatic logic [4:0] rc_next(input logic [4:0] rc);
        return {rc[3:0], rc[4] ^ rc[2]};
    endfunction

endpackage

// File: rtl/rectangle_key_sched_if.sv
// rectangle_key_sched_if: key load and round-key stream bundle (rd_* only with RECT_RKEY_STORE_EN)
interface rectangle_key_sched_if #(parameter int KEY_W = 80);
    logic             key_load;
    logic [KEY_W-1:0] key_in;
    logic             key_ready;
    logic             rk_valid;
    logic             rk_ready;
    logic [63:0]      rk_out;
    logic [4:0]       rk_idx;
    logic             sched_done;
`ifdef RECT_RKEY_STORE_EN
    logic             rd_en;
    logic [4:0]       rd_idx;
    logic [63:0]      rd_data;
    logic             rd_valid;
`endif

    modport master (
        output key_load, key_in, rk_ready,
        input  key_ready, rk_valid, rk_out, rk_idx, sched_done
`ifdef RECT_RKEY_STORE_EN
        , output rd_en, rd_idx,
        input  rd_data, rd_valid
`endif
    );

    modport slave (
        input  key_load, key_in, rk_ready,
        output key_ready, rk_valid, rk_out, rk_idx, sched_done
`ifdef RECT_RKEY_STORE_EN
        , input rd_en, rd_idx,
        output rd_data, rd_valid
`endif
    );
endinterface

// File: rtl/rectangle_key_sched_sbox_layer.sv
// rect_ks_sbox_layer: applies the 4-bit S-box to the low COLS columns of a 4-row array
module rect_sbox4 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    import rectangle_pkg::*;
    assign dout = SBOX[din];
endmodule

module rect_ks_sbox_layer #(
    parameter int COLS  = 4,
    parameter int ROW_W = 16
) (
    input  logic [4*ROW_W-1:0] rows_in,
    output logic [4*ROW_W-1:0] rows_out
);
    for (genvar c = 0; c < ROW_W; c++) begin : g_col
        if (c < COLS) begin : g_s
            logic [3:0] nib;
            rect_sbox4 u_sbox (
                .din ({rows_in[3*ROW_W+c], rows_in[2*ROW_W+c], rows_in[ROW_W+c], rows_in[c]}),
                .dout(nib)
            );
            assign {rows_out[3*ROW_W+c], rows_out[2*ROW_W+c], rows_out[ROW_W+c], rows_out[c]} = nib;
        end else begin : g_p
            assign {rows_out[3*ROW_W+c], rows_out[2*ROW_W+c], rows_out[ROW_W+c], rows_out[c]} =
                   {rows_in[3*ROW_W+c], rows_in[2*ROW_W+c], rows_in[ROW_W+c], rows_in[c]};
        end
    end
endmodule

// File: rtl/rectangle_key_sched.sv
// rectangle_key_sched: streams ROUNDS+1 RECTANGLE round keys per 80/128-bit master key
// Optional round-key store enabled by defining RECT_RKEY_STORE_EN
module rectangle_key_sched
    import rectangle_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 25
) (
    input logic clk,
    input logic rst_n,
    rectangle_key_sched_if.slave bus
);
    localparam int ROW_W = row_w(KEY_W);
    localparam int COLS  = col_n(KEY_W);
    localparam int SB_W  = 4 * ROW_W;

    ks_state_t        state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d, key_upd;
    logic [SB_W-1:0]  sb_out;
    logic [4:0]       rc_q, rc_d, idx_q, idx_d;
    logic             load, fire, last;
    rk_t              rk;

    rect_ks_sbox_layer #(.COLS(COLS), .ROW_W(ROW_W)) u_sbox (
        .rows_in (key_q[SB_W-1:0]),
        .rows_out(sb_out)
    );

    if (KEY_W == 80) begin : g_k80
        logic [15:0] s0, s1, s2, s3, n0;
        assign {s3, s2, s1, s0} = sb_out;
        assign n0      = {s0[7:0], s0[15:8]} ^ s1 ^ {11'd0, rc_q};
        assign key_upd = {s0, {s3[3:0], s3[15:4]} ^ key_q[79:64], s3, s2, n0};
        assign rk      = key_q[63:0];
    end else if (KEY_W == 128) begin : g_k128
        logic [31:0] s0, s1, s2, s3, n0;
        assign {s3, s2, s1, s0} = sb_out;
        assign n0      = {s0[23:0], s0[31:24]} ^ s1 ^ {27'd0, rc_q};
        assign key_upd = {s0, {s2[15:0], s2[31:16]} ^ s3, s2, n0};
        assign rk      = {key_q[111:96], key_q[79:64], key_q[47:32], key_q[15:0]};
    end else begin : g_bad
        $error("rectangle_key_sched: KEY_W must be 80 or 128");
    end

    assign load = (state_q == IDLE) && bus.key_load;
    assign fire = (state_q == EMIT) && bus.rk_ready;
    assign last = idx_q == 5'(ROUNDS);

    // next-state: capture on load, step the key on every non-final acceptance
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        idx_d   = idx_q;
        if (load) begin
            state_d = EMIT;
            key_d   = bus.key_in;
            rc_d    = RC_INIT;
            idx_d   = '0;
        end else if (fire && last) begin
            state_d = IDLE;
        end else if (fire) begin
            key_d = key_upd;
            rc_d  = rc_next(rc_q);
            idx_d = idx_q + 5'd1;
        end
    end

    // schedule state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rc_q    <= RC_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.key_ready  = state_q == IDLE;
    assign bus.rk_valid   = state_q == EMIT;
    assign bus.rk_out     = rk;
    assign bus.rk_idx     = idx_q;
    assign bus.sched_done = fire && last;

`ifdef RECT_RKEY_STORE_EN
    rk_t           mem [ROUNDS+1];
    logic [ROUNDS:0] wr_ok;
    logic          rd_ok;
    rk_t           rd_data_q;
    logic          rd_valid_q;

    assign rd_ok = (bus.rd_idx <= 5'(ROUNDS)) && wr_ok[bus.rd_idx];

    // store every accepted round key at its index
    always_ff @(posedge clk) begin
        if (fire) mem[idx_q] <= rk;
    end

    // entry valid bits (cleared per load) and the registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ok      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (load) wr_ok <= '0;
            else if (fire) wr_ok[idx_q] <= 1'b1;
            rd_valid_q <= bus.rd_en && rd_ok;
            if (bus.rd_en && rd_ok) rd_data_q <= mem[bus.rd_idx];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_rectangle_key_sched.sv
// tb_rectangle_key_sched: randomized check of both key widths against a software RECTANGLE model
module tb_rectangle_key_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rectangle_key_sched_if #(.KEY_W(80))  b80 ();
    rectangle_key_sched_if #(.KEY_W(128)) b128 ();

    rectangle_key_sched #(.KEY_W(80), .ROUNDS(25)) dut80 (.clk(clk), .rst_n(rst_n), .bus(b80));
    rectangle_key_sched #(.KEY_W(128), .ROUNDS(25)) dut128 (.clk(clk), .rst_n(rst_n), .bus(b128));

    int nvec = 0;
    int nerr = 0;
    logic [63:0] sbp = 64'h24F8D30B97E1AC56;
    logic [63:0] exp_rk [26];
    logic [4:0]  exp_rc [26];
    logic [63:0] got_rk [26];
    logic [4:0]  got_idx [26];
    logic [4:0]  got_rc [26];
    int n_got, done_at, ndone, stall_bad;
    bit first_valid, idle_after;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n, input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        return ((x << n) | (x >> (w - n))) & m;
    endfunction

    function automatic logic [127:0] step(input logic [127:0] k, input bit w128, input logic [4:0] rc);
        int w, nr, nc;
        logic [31:0] r [5];
        logic [31:0] n [5];
        logic [3:0] x, y;
        logic [127:0] o;
        w = w128 ? 32 : 16;
        nr = w128 ? 4 : 5;
        nc = w128 ? 8 : 4;
        for (int i = 0; i < 5; i++) r[i] = (i < nr) ? 32'((k >> (w * i)) & ((128'd1 << w) - 1)) : 32'd0;
        for (int c = 0; c < nc; c++) begin
            x = {r[3][c], r[2][c], r[1][c], r[0][c]};
            y = 4'(sbp >> (4 * int'(x)));
            for (int j = 0; j < 4; j++) r[j][c] = y[j];
        end
        if (w128) begin
            n[0] = rol(r[0], 8, 32) ^ r[1];
            n[1] = r[2];
            n[2] = rol(r[2], 16, 32) ^ r[3];
            n[3] = r[0];
            n[4] = 32'd0;
        end else begin
            n[0] = rol(r[0], 8, 16) ^ r[1];
            n[1] = r[2];
            n[2] = r[3];
            n[3] = rol(r[3], 12, 16) ^ r[4];
            n[4] = r[0];
        end
        n[0] = n[0] ^ 32'(rc);
        o = '0;
        for (int i = 0; i < nr; i++) o = o | (128'(n[i]) << (w * i));
        return o;
    endfunction

    function automatic logic [63:0] rk_of(input logic [127:0] k, input bit w128);
        return w128 ? {k[111:96], k[79:64], k[47:32], k[15:0]} : k[63:0];
    endfunction

    task automatic model(input bit w128, input logic [127:0] key);
        logic [127:0] k;
        logic [4:0] rc;
        k = key;
        rc = 5'h01;
        for (int i = 0; i < 26; i++) begin
            exp_rk[i] = rk_of(k, w128);
            exp_rc[i] = rc;
            k = step(k, w128, rc);
            rc = {rc[3:0], rc[4] ^ rc[2]};
        end
    endtask

    task automatic collect(input bit w128, input logic [127:0] key, input int stall_pct, input bit poke);
        bit rdy, v, d, stalled;
        logic [63:0] o, po;
        logic [4:0] ix, pix;
        int cyc;
        n_got = 0; done_at = -1; ndone = 0; stall_bad = 0; stalled = 0; cyc = 0; po = '0; pix = '0;
        @(negedge clk);
        if (w128) begin b128.key_load = 1'b1; b128.key_in = key; end
        else begin b80.key_load = 1'b1; b80.key_in = key[79:0]; end
        @(negedge clk);
        b80.key_load = 1'b0;
        b128.key_load = 1'b0;
        first_valid = w128 ? b128.rk_valid : b80.rk_valid;
        while (n_got < 26 && cyc < 1000) begin
            rdy = ($urandom_range(99) >= stall_pct);
            if (w128) begin
                b128.rk_ready = rdy;
                if (poke) begin b128.key_load = 1'b1; b128.key_in = {$urandom(), $urandom(), $urandom(), $urandom()}; end
            end else begin
                b80.rk_ready = rdy;
                if (poke) begin b80.key_load = 1'b1; b80.key_in = 80'({$urandom(), $urandom(), $urandom()}); end
            end
            #1;
            v  = w128 ? b128.rk_valid : b80.rk_valid;
            o  = w128 ? b128.rk_out : b80.rk_out;
            ix = w128 ? b128.rk_idx : b80.rk_idx;
            d  = w128 ? b128.sched_done : b80.sched_done;
            if (stalled && (o !== po || ix !== pix)) stall_bad++;
            if (v && rdy) begin
                got_rk[n_got] = o;
                got_idx[n_got] = ix;
                got_rc[n_got] = w128 ? dut128.rc_q : dut80.rc_q;
                if (d) done_at = n_got;
                n_got++;
            end
            if (d) ndone++;
            stalled = v && !rdy;
            po = o;
            pix = ix;
            @(negedge clk);
            cyc++;
        end
        b80.rk_ready = 1'b0; b128.rk_ready = 1'b0;
        b80.key_load = 1'b0; b128.key_load = 1'b0;
        #1;
        idle_after = w128 ? (b128.key_ready && !b128.rk_valid && !b128.sched_done)
                          : (b80.key_ready && !b80.rk_valid && !b80.sched_done);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        nvec += 10;
        if (b80.key_ready !== 1'b1) begin nerr++; $display("FAIL reset80_key_ready got %b exp 1", b80.key_ready); end
        if (b80.rk_valid !== 1'b0) begin nerr++; $display("FAIL reset80_rk_valid got %b exp 0", b80.rk_valid); end
        if (b80.rk_out !== 64'd0) begin nerr++; $display("FAIL reset80_rk_out got %h exp 0", b80.rk_out); end
        if (b80.rk_idx !== 5'd0) begin nerr++; $display("FAIL reset80_rk_idx got %0d exp 0", b80.rk_idx); end
        if (b80.sched_done !== 1'b0) begin nerr++; $display("FAIL reset80_done got %b exp 0", b80.sched_done); end
        if (b128.key_ready !== 1'b1) begin nerr++; $display("FAIL reset128_key_ready got %b exp 1", b128.key_ready); end
        if (b128.rk_valid !== 1'b0) begin nerr++; $display("FAIL reset128_rk_valid got %b exp 0", b128.rk_valid); end
        if (b128.rk_out !== 64'd0) begin nerr++; $display("FAIL reset128_rk_out got %h exp 0", b128.rk_out); end
        if (b128.rk_idx !== 5'd0) begin nerr++; $display("FAIL reset128_rk_idx got %0d exp 0", b128.rk_idx); end
        if (dut80.rc_q !== 5'h01) begin nerr++; $display("FAIL reset80_rc got %h exp 01", dut80.rc_q); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        nvec++;
        if (b80.key_ready !== 1'b1 || b80.rk_valid !== 1'b0) begin
            nerr++; $display("FAIL post_reset_idle got ready=%b valid=%b exp 1/0", b80.key_ready, b80.rk_valid);
        end
    endtask

    task automatic test_zero80();
        model(1'b0, '0);
        collect(1'b0, '0, 0, 1'b0);
        nvec += 7;
        if (!first_valid) begin nerr++; $display("FAIL zero80_latency got valid=0 exp 1"); end
        if (n_got !== 26) begin nerr++; $display("FAIL zero80_count got %0d exp 26", n_got); end
        if (got_rk[0] !== 64'h0) begin nerr++; $display("FAIL zero80_rk0 got %h exp 0", got_rk[0]); end
        if (got_rk[1] !== 64'h0000_0000_000F_000E) begin nerr++; $display("FAIL zero80_rk1 got %h exp 000000000000f000e", got_rk[1]); end
        if (ndone !== 1 || done_at !== 25) begin nerr++; $display("FAIL zero80_done got n=%0d at=%0d exp 1 at 25", ndone, done_at); end
        if (!idle_after) begin nerr++; $display("FAIL zero80_idle got busy exp idle"); end
        if (n_got !== 26) begin nerr++; $display("FAIL zero80_full got %0d keys exp 26", n_got); end
        for (int i = 0; i < n_got; i++) begin
            nvec += 2;
            if (got_idx[i] !== 5'(i)) begin nerr++; $display("FAIL zero80_idx[%0d] got %0d exp %0d", i, got_idx[i], i); end
            if (got_rk[i] !== exp_rk[i]) begin nerr++; $display("FAIL zero80_rk[%0d] got %h exp %h", i, got_rk[i], exp_rk[i]); end
        end
    endtask

    task automatic test_random80();
        logic [4:0] rc_tab [6];
        logic [127:0] k;
        rc_tab = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05};
        for (int t = 0; t < 3; t++) begin
            k = 128'({$urandom(), $urandom(), $urandom()}) & ((128'd1 << 80) - 1);
            model(1'b0, k);
            collect(1'b0, k, 0, 1'b0);
            nvec++;
            if (n_got !== 26) begin nerr++; $display("FAIL rand80_count got %0d exp 26", n_got); end
            for (int i = 0; i < n_got; i++) begin
                nvec += 2;
                if (got_rk[i] !== exp_rk[i]) begin nerr++; $display("FAIL rand80_rk[%0d] got %h exp %h", i, got_rk[i], exp_rk[i]); end
                if (got_rc[i] !== exp_rc[i]) begin nerr++; $display("FAIL rand80_rc[%0d] got %h exp %h", i, got_rc[i], exp_rc[i]); end
            end
            for (int i = 0; i < 6 && i < n_got; i++) begin
                nvec++;
                if (got_rc[i] !== rc_tab[i]) begin nerr++; $display("FAIL rc_seq[%0d] got %h exp %h", i, got_rc[i], rc_tab[i]); end
            end
        end
    endtask

    task automatic test_key128();
        logic [127:0] k;
        model(1'b1, '0);
        collect(1'b1, '0, 0, 1'b0);
        nvec += 4;
        if (n_got !== 26) begin nerr++; $display("FAIL zero128_count got %0d exp 26", n_got); end
        if (got_rk[0] !== 64'h0) begin nerr++; $display("FAIL zero128_rk0 got %h exp 0", got_rk[0]); end
        if (got_rk[1] !== 64'h0000_0000_00FF_00FE) begin nerr++; $display("FAIL zero128_rk1 got %h exp 00000000000ff00fe", got_rk[1]); end
        if (ndone !== 1 || done_at !== 25) begin nerr++; $display("FAIL zero128_done got n=%0d at=%0d exp 1 at 25", ndone, done_at); end
        for (int i = 0; i < n_got; i++) begin
            nvec++;
            if (got_rk[i] !== exp_rk[i]) begin nerr++; $display("FAIL zero128_rk[%0d] got %h exp %h", i, got_rk[i], exp_rk[i]); end
        end
        for (int t = 0; t < 2; t++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            model(1'b1, k);
            collect(1'b1, k, 0, 1'b0);
            nvec++;
            if (n_got !== 26) begin nerr++; $display("FAIL rand128_count got %0d exp 26", n_got); end
            for (int i = 0; i < n_got; i++) begin
                nvec++;
                if (got_rk[i] !== exp_rk[i]) begin nerr++; $display("FAIL rand128_rk[%0d] got %h exp %h", i, got_rk[i], exp_rk[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] k;
        for (int t = 0; t < 2; t++) begin
            k = (t == 0) ? (128'({$urandom(), $urandom(), $urandom()}) & ((128'd1 << 80) - 1))
                         : {$urandom(), $urandom(), $urandom(), $urandom()};
            model(t == 1, k);
            collect(t == 1, k, 50, 1'b1);
            nvec += 4;
            if (n_got !== 26) begin nerr++; $display("FAIL bp%0d_count got %0d exp 26", t, n_got); end
            if (stall_bad !== 0) begin nerr++; $display("FAIL bp%0d_stall_stable got %0d changes exp 0", t, stall_bad); end
            if (ndone !== 1 || done_at !== 25) begin nerr++; $display("FAIL bp%0d_done got n=%0d at=%0d exp 1 at 25", t, ndone, done_at); end
            if (!idle_after) begin nerr++; $display("FAIL bp%0d_final_load got busy exp idle", t); end
            for (int i = 0; i < n_got; i++) begin
                nvec += 2;
                if (got_rk[i] !== exp_rk[i]) begin nerr++; $display("FAIL bp%0d_rk[%0d] got %h exp %h", t, i, got_rk[i], exp_rk[i]); end
                if (got_idx[i] !== 5'(i)) begin nerr++; $display("FAIL bp%0d_idx[%0d] got %0d exp %0d", t, i, got_idx[i], i); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] k;
        @(negedge clk);
        b80.key_load = 1'b1;
        b80.key_in = 80'({$urandom(), $urandom(), $urandom()});
        @(negedge clk);
        b80.key_load = 1'b0;
        b80.rk_ready = 1'b1;
        for (int i = 0; i < 40 && b80.rk_idx !== 5'd12; i++) @(negedge clk);
        nvec++;
        if (b80.rk_idx !== 5'd12) begin nerr++; $display("FAIL mid_reach12 got %0d exp 12", b80.rk_idx); end
        rst_n = 1'b0;
        b80.rk_ready = 1'b0;
        #1;
        nvec += 6;
        if (b80.key_ready !== 1'b1) begin nerr++; $display("FAIL mid_key_ready got %b exp 1", b80.key_ready); end
        if (b80.rk_valid !== 1'b0) begin nerr++; $display("FAIL mid_rk_valid got %b exp 0", b80.rk_valid); end
        if (b80.rk_out !== 64'd0) begin nerr++; $display("FAIL mid_rk_out got %h exp 0", b80.rk_out); end
        if (b80.rk_idx !== 5'd0) begin nerr++; $display("FAIL mid_rk_idx got %0d exp 0", b80.rk_idx); end
        if (b80.sched_done !== 1'b0) begin nerr++; $display("FAIL mid_done got %b exp 0", b80.sched_done); end
        if (dut80.rc_q !== 5'h01) begin nerr++; $display("FAIL mid_rc got %h exp 01", dut80.rc_q); end
        @(negedge clk);
        rst_n = 1'b1;
        k = 128'({$urandom(), $urandom(), $urandom()}) & ((128'd1 << 80) - 1);
        model(1'b0, k);
        collect(1'b0, k, 0, 1'b0);
        nvec += 3;
        if (n_got !== 26) begin nerr++; $display("FAIL mid_restart_count got %0d exp 26", n_got); end
        if (got_idx[0] !== 5'd0) begin nerr++; $display("FAIL mid_restart_idx got %0d exp 0", got_idx[0]); end
        if (got_rc[0] !== 5'h01) begin nerr++; $display("FAIL mid_restart_rc got %h exp 01", got_rc[0]); end
        for (int i = 0; i < n_got; i++) begin
            nvec++;
            if (got_rk[i] !== exp_rk[i]) begin nerr++; $display("FAIL mid_restart_rk[%0d] got %h exp %h", i, got_rk[i], exp_rk[i]); end
        end
    endtask

`ifdef RECT_RKEY_STORE_EN
    task automatic test_store();
        collect(1'b0, '0, 0, 1'b0);
        @(negedge clk);
        b80.rd_en = 1'b1;
        b80.rd_idx = 5'd1;
        @(negedge clk);
        #1;
        nvec += 2;
        if (b80.rd_valid !== 1'b1) begin nerr++; $display("FAIL store_rd1_valid got %b exp 1", b80.rd_valid); end
        if (b80.rd_data !== 64'h0000_0000_000F_000E) begin nerr++; $display("FAIL store_rd1_data got %h exp 000000000000f000e", b80.rd_data); end
        b80.rd_idx = 5'd26;
        @(negedge clk);
        #1;
        nvec++;
        if (b80.rd_valid !== 1'b0) begin nerr++; $display("FAIL store_rd26_valid got %b exp 0", b80.rd_valid); end
        b80.rd_en = 1'b0;
        b80.key_load = 1'b1;
        b80.key_in = 80'({$urandom(), $urandom(), $urandom()});
        @(negedge clk);
        b80.key_load = 1'b0;
        b80.rd_en = 1'b1;
        b80.rd_idx = 5'd5;
        @(negedge clk);
        #1;
        nvec++;
        if (b80.rd_valid !== 1'b0) begin nerr++; $display("FAIL store_invalidated got %b exp 0", b80.rd_valid); end
        b80.rd_en = 1'b0;
        b80.rk_ready = 1'b1;
        for (int i = 0; i < 100 && !b80.key_ready; i++) @(negedge clk);
        b80.rk_ready = 1'b0;
        nvec++;
        if (b80.key_ready !== 1'b1) begin nerr++; $display("FAIL store_drain got ready=%b exp 1", b80.key_ready); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        b80.key_load = 1'b0; b80.key_in = '0; b80.rk_ready = 1'b0;
        b128.key_load = 1'b0; b128.key_in = '0; b128.rk_ready = 1'b0;
`ifdef RECT_RKEY_STORE_EN
        b80.rd_en = 1'b0; b80.rd_idx = '0;
        b128.rd_en = 1'b0; b128.rd_idx = '0;
`endif
        test_reset();
        test_zero80();
        test_random80();
        test_key128();
        test_backpressure();
        test_reset_mid();
`ifdef RECT_RKEY_STORE_EN
        test_store();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
